// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared state type and default sizing for the tick generator.
// Build option TICK_GEN_SYNC_EN lengthens arming to fill the input synchronizer.
package tick_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } tick_state_t;

    localparam int TG_WIDTH = 32;
    localparam int TG_SEL_W = 5;
    localparam int TG_CNT_W = 8;

`ifdef TICK_GEN_SYNC_EN
    localparam int ARM_CYCLES = 3;
`else
    localparam int ARM_CYCLES = 1;
`endif

endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: divider-facing inputs and enable-pulse outputs of tick_gen.
// master drives divider bus / controls, slave is the tick generator.
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int WIDTH = TG_WIDTH,
    parameter int SEL_W = TG_SEL_W,
    parameter int CNT_W = TG_CNT_W
);
    logic [WIDTH-1:0] divided_clocks;
    logic [SEL_W-1:0] sel;
    logic             enable;
    logic [CNT_W-1:0] period;
    logic             tick;
    logic             strobe;
    logic [CNT_W-1:0] tick_count;
    logic             busy;

    modport master (
        output divided_clocks, sel, enable, period,
        input  tick, strobe, tick_count, busy
    );

    modport slave (
        input  divided_clocks, sel, enable, period,
        output tick, strobe, tick_count, busy
    );
endinterface

// File: rtl/tick_gen_rise_detect.sv
// rise_detect: rising-edge detector with a preset (load) port.
// With TICK_GEN_SYNC_EN the input first passes a 2-flop synchronizer.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bit,
    input  logic i_load,
    input  logic i_en,
    output logic o_rise
);
    logic r_prev;
    logic w_cur;

`ifdef TICK_GEN_SYNC_EN
    logic [1:0] r_sync;

    // two-stage synchronizer for a bit from a foreign clock domain
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= '0;
        else       r_sync <= {r_sync[0], i_bit};
    end

    assign w_cur = r_sync[1];
`else
    assign w_cur = i_bit;
`endif

    // previous-sample register; load presets it so an already-high bit is not an edge
    always_ff @(posedge i_clk) begin
        if (i_rst)                r_prev <= 1'b0;
        else if (i_load || i_en)  r_prev <= w_cur;
    end

    assign o_rise = i_en & w_cur & ~r_prev;
endmodule

// File: rtl/tick_gen.sv
// tick_gen: turns rising edges of a selected divider bit into one-cycle tick
// enables, plus a strobe every `period` ticks with a running tick_count.
// Build option TICK_GEN_SYNC_EN adds a 2-flop synchronizer (+2 cycles latency).
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int WIDTH = TG_WIDTH,
    parameter int SEL_W = TG_SEL_W,
    parameter int CNT_W = TG_CNT_W
) (
    input logic       clock,
    input logic       reset,
    tick_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    tick_state_t      r_state, w_next;
    logic [SEL_W-1:0] r_sel_q, w_sel_nxt;
    logic [CNT_W-1:0] r_period_q, w_period_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic             r_tick, w_tick_nxt;
    logic             r_strobe, w_strobe_nxt;
    logic             r_busy;
    logic [1:0]       r_arm_cnt;

    logic [SEL_W-1:0] w_sel_idx;
    logic             w_bit;
    logic             w_rise;
    logic [CNT_W-1:0] w_period_eff;

    // while arming, track the incoming sel so the detector presets from the new bit
    assign w_sel_idx    = (r_state == RUN) ? r_sel_q : bus.sel;
    assign w_bit        = bus.divided_clocks[w_sel_idx];
    assign w_period_eff = (bus.period == '0) ? ONE : bus.period;

    rise_detect u_rise (
        .i_clk  (clock),
        .i_rst  (reset),
        .i_bit  (w_bit),
        .i_load (r_state == ARM),
        .i_en   (r_state == RUN),
        .o_rise (w_rise)
    );

    // next-state and next-output decode; disable overrides every state
    always_comb begin
        w_next       = r_state;
        w_sel_nxt    = r_sel_q;
        w_period_nxt = r_period_q;
        w_count_nxt  = r_count;
        w_tick_nxt   = 1'b0;
        w_strobe_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                w_next      = ARM;
            end
            ARM: begin
                w_sel_nxt    = bus.sel;
                w_period_nxt = w_period_eff;
                w_count_nxt  = '0;
                if (r_arm_cnt == 2'(ARM_CYCLES - 1)) w_next = RUN;
            end
            RUN: begin
                if (bus.sel != r_sel_q) begin
                    w_next      = ARM;
                    w_count_nxt = '0;
                end else if (w_rise) begin
                    w_tick_nxt = 1'b1;
                    if (r_count == r_period_q - ONE) begin
                        w_count_nxt  = '0;
                        w_strobe_nxt = 1'b1;
                        w_period_nxt = w_period_eff;
                    end else begin
                        w_count_nxt = r_count + ONE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (!bus.enable) begin
            w_next       = IDLE;
            w_count_nxt  = '0;
            w_tick_nxt   = 1'b0;
            w_strobe_nxt = 1'b0;
        end
    end

    // state, latched configuration and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_sel_q    <= '0;
            r_period_q <= ONE;
            r_count    <= '0;
            r_tick     <= 1'b0;
            r_strobe   <= 1'b0;
            r_busy     <= 1'b0;
            r_arm_cnt  <= '0;
        end else begin
            r_state    <= w_next;
            r_sel_q    <= w_sel_nxt;
            r_period_q <= w_period_nxt;
            r_count    <= w_count_nxt;
            r_tick     <= w_tick_nxt;
            r_strobe   <= w_strobe_nxt;
            r_busy     <= (w_next != IDLE);
            r_arm_cnt  <= (r_state == ARM && w_next == ARM) ? r_arm_cnt + 2'd1 : 2'd0;
        end
    end

    assign bus.tick       = r_tick;
    assign bus.strobe     = r_strobe;
    assign bus.tick_count = r_count;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed scenarios plus randomized traffic against a
// rule-level reference model of the tick generator.
module tb_tick_gen;
    import tick_gen_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] div;

    tick_gen_if #(.WIDTH(TG_WIDTH), .SEL_W(TG_SEL_W), .CNT_W(TG_CNT_W)) bus ();

    tick_gen #(.WIDTH(TG_WIDTH), .SEL_W(TG_SEL_W), .CNT_W(TG_CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // reference model: rule-level description of what the block promises
    bit       m_active;   // enable has been seen while not idle
    bit       m_have_ref; // reference sample of the tracked bit captured
    bit       m_ref;
    int       m_glen;     // length of the current strobe group
    int       m_gsel;
    bit       e_tick, e_strobe, e_busy;
    int       e_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_period(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_step();
        bit cur;
        if (reset) begin
            m_active = 0; m_have_ref = 0; m_ref = 0; m_glen = 1; m_gsel = 0;
            e_tick = 0; e_strobe = 0; e_cnt = 0; e_busy = 0;
        end else if (!bus.enable) begin
            m_active = 0; m_have_ref = 0;
            e_tick = 0; e_strobe = 0; e_cnt = 0; e_busy = 0;
        end else if (!m_active) begin
            m_active = 1;
            e_tick = 0; e_strobe = 0; e_cnt = 0; e_busy = 1;
        end else if (!m_have_ref) begin
            m_gsel = int'(bus.sel);
            m_glen = eff_period(int'(bus.period));
            m_ref = div[m_gsel];
            m_have_ref = 1;
            e_tick = 0; e_strobe = 0; e_cnt = 0; e_busy = 1;
        end else if (int'(bus.sel) != m_gsel) begin
            m_have_ref = 0;
            e_tick = 0; e_strobe = 0; e_cnt = 0; e_busy = 1;
        end else begin
            cur = div[m_gsel];
            e_tick = cur && !m_ref;
            m_ref = cur;
            e_strobe = 0;
            if (e_tick) begin
                e_cnt++;
                if (e_cnt == m_glen) begin
                    e_cnt = 0;
                    e_strobe = 1;
                    m_glen = eff_period(int'(bus.period));
                end
            end
        end
    endtask

    // one clock: model sees the same inputs the DUT sampled, then outputs compared
    task automatic cycle();
        @(posedge clock);
        #1;
        model_step();
        check("tick",       32'(bus.tick),       32'(e_tick));
        check("strobe",     32'(bus.strobe),     32'(e_strobe));
        check("tick_count", 32'(bus.tick_count), 32'(e_cnt));
        check("busy",       32'(bus.busy),       32'(e_busy));
        div = div + 32'd1;
        bus.divided_clocks = div;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int seen;
        div = 32'h0;
        reset = 1'b1;
        bus.divided_clocks = div;
        bus.sel = '0;
        bus.enable = 1'b1;
        bus.period = 8'd3;

        // reset held with enable high, then busy one cycle after release
        run(3);
        reset = 1'b0;
        run(2);

        // fast rate on bit 0, period 3
        run(40);

        // arm while bit 2 is already high
        bus.enable = 1'b0;
        run(2);
        bus.sel = 5'd2;
        div = 32'h4;
        bus.divided_clocks = div;
        bus.enable = 1'b1;
        run(24);

        // period 4 then changed mid-group to 2, then 0
        bus.sel = 5'd1;
        bus.period = 8'd4;
        run(10);
        bus.period = 8'd2;
        run(30);
        bus.period = 8'd0;
        run(16);

        // sel change mid-run
        bus.period = 8'd4;
        run(14);
        bus.sel = 5'd3;
        run(40);

        // disable on both parities of bit-0 edges
        bus.sel = 5'd0;
        run(6);
        bus.enable = 1'b0;
        run(1);
        bus.enable = 1'b1;
        run(5);
        bus.enable = 1'b0;
        run(1);
        bus.enable = 1'b1;
        run(6);

        // reset landing on a strobe cycle
        bus.period = 8'd1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            cycle();
            if (bus.strobe === 1'b1) seen = 1;
        end
        check("strobe_seen", 32'(seen), 32'd1);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        run(4);

        // counter wrap: all ones -> 0 must not tick
        bus.sel = 5'd4;
        bus.period = 8'd2;
        run(4);
        div = 32'hFFFF_FFFE;
        bus.divided_clocks = div;
        run(6);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63, 0) == 0) bus.enable = ~bus.enable;
            if ($urandom_range(39, 0) == 0) bus.sel = 5'($urandom_range(5, 0));
            if ($urandom_range(29, 0) == 0) begin
                case ($urandom_range(6, 0))
                    0:       bus.period = 8'd0;
                    1:       bus.period = 8'd1;
                    2:       bus.period = 8'd2;
                    3:       bus.period = 8'd3;
                    4:       bus.period = 8'd255;
                    default: bus.period = 8'($urandom_range(255, 0));
                endcase
            end
            if ($urandom_range(199, 0) == 0) begin
                div = 32'hFFFF_FFFF;
                bus.divided_clocks = div;
            end
            reset = ($urandom_range(299, 0) == 0);
            cycle();
        end
        reset = 1'b0;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
